// File: rtl/matrix_mac_sequencer_pkg.sv
// matrix_mac_sequencer_pkg: state encoding and default lane/width constants shared by the sequencer
package matrix_mac_sequencer_pkg;

    localparam int DEF_IN_PORTS  = 4;
    localparam int DEF_OUT_PORTS = 4;
    localparam int DEF_BIT_LEN   = 32;
    localparam int DEF_CNT_W     = 16;
    localparam int DEF_WD_LIMIT  = 255;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        ACCUM = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/matrix_mac_sequencer_if.sv
// matrix_mac_sequencer_if: operand beat handshake plus multiplier/adder control bundle
interface matrix_mac_sequencer_if import matrix_mac_sequencer_pkg::*; #(
    parameter int IN_PORTS  = DEF_IN_PORTS,
    parameter int OUT_PORTS = DEF_OUT_PORTS,
    parameter int BIT_LEN   = DEF_BIT_LEN,
    parameter int CNT_W     = DEF_CNT_W
) ();

    logic                        op_valid;
    logic                        op_ready;
    logic [IN_PORTS*BIT_LEN-1:0] op_a;
    logic [IN_PORTS*BIT_LEN-1:0] op_b;
    logic                        op_last;
    logic [OUT_PORTS-1:0]        add_mask;
    logic [IN_PORTS*BIT_LEN-1:0] multiplier_input;
    logic [IN_PORTS*BIT_LEN-1:0] multiplicand_input;
    logic [IN_PORTS-1:0]         mStart;
    logic [IN_PORTS-1:0]         mReady;
    logic [OUT_PORTS-1:0]        Add;
    logic                        sum_valid;
    logic [CNT_W-1:0]            beat_count;
    logic                        err;

    modport master (
        output op_valid, op_a, op_b, op_last, add_mask, mReady,
        input  op_ready, multiplier_input, multiplicand_input, mStart, Add, sum_valid, beat_count, err
    );

    modport slave (
        input  op_valid, op_a, op_b, op_last, add_mask, mReady,
        output op_ready, multiplier_input, multiplicand_input, mStart, Add, sum_valid, beat_count, err
    );

endinterface

// File: rtl/matrix_mac_sequencer_ready_tracker.sv
// mac_ready_tracker: sticky per-lane ready collection with optional watchdog (MATRIX_MAC_SEQ_WATCHDOG_EN)
module mac_ready_tracker import matrix_mac_sequencer_pkg::*; #(
    parameter int IN_PORTS = DEF_IN_PORTS,
    parameter int WD_LIMIT = DEF_WD_LIMIT
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                clr,
    input  logic                en,
    input  logic [IN_PORTS-1:0] m_ready,
    output logic                all_ready,
    output logic                timeout
);

    logic [IN_PORTS-1:0] rdy_s;

    assign all_ready = en && (&(rdy_s | m_ready));

    // lanes latch ready only while waiting; START clears so stale ready is discarded
    always_ff @(posedge Clk or posedge Rst)
        if (Rst)
            rdy_s <= '0;
        else if (clr)
            rdy_s <= '0;
        else if (en)
            rdy_s <= rdy_s | m_ready;

`ifdef MATRIX_MAC_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_LIMIT + 1);

    logic [WD_W-1:0] wd_cnt;

    assign timeout = en && !all_ready && (wd_cnt == WD_W'(WD_LIMIT - 1));

    // counts WAIT cycles from 0; timeout fires on the cycle the limit would be reached
    always_ff @(posedge Clk or posedge Rst)
        if (Rst)
            wd_cnt <= '0;
        else if (clr)
            wd_cnt <= '0;
        else if (en)
            wd_cnt <= wd_cnt + 1'b1;
`else
    assign timeout = WD_LIMIT < 0;
`endif

endmodule

// File: rtl/matrix_mac_sequencer.sv
// matrix_mac_sequencer: per-beat multiply/accumulate sequencing; optional watchdog via MATRIX_MAC_SEQ_WATCHDOG_EN
module matrix_mac_sequencer import matrix_mac_sequencer_pkg::*; #(
    parameter int IN_PORTS  = DEF_IN_PORTS,
    parameter int OUT_PORTS = DEF_OUT_PORTS,
    parameter int WD_LIMIT  = DEF_WD_LIMIT
) (
    input logic                   Clk,
    input logic                   Rst,
    matrix_mac_sequencer_if.slave bus
);

    state_t               state;
    logic                 last_q;
    logic                 new_grp;
    logic                 all_ready;
    logic                 timeout;
    logic [OUT_PORTS-1:0] mask_q;

    assign bus.op_ready = (state == IDLE) && !Rst;

    mac_ready_tracker #(.IN_PORTS(IN_PORTS), .WD_LIMIT(WD_LIMIT)) u_trk (
        .Clk       (Clk),
        .Rst       (Rst),
        .clr       (state == START),
        .en        (state == WAIT),
        .m_ready   (bus.mReady),
        .all_ready (all_ready),
        .timeout   (timeout)
    );

    // sequencer FSM; strobes are registered so they coincide with their state
    always_ff @(posedge Clk or posedge Rst)
        if (Rst) begin
            state                  <= IDLE;
            last_q                 <= 1'b0;
            new_grp                <= 1'b0;
            mask_q                 <= '0;
            bus.multiplier_input   <= '0;
            bus.multiplicand_input <= '0;
            bus.mStart             <= '0;
            bus.Add                <= '0;
            bus.sum_valid          <= 1'b0;
            bus.beat_count         <= '0;
            bus.err                <= 1'b0;
        end else begin
            bus.mStart    <= '0;
            bus.Add       <= '0;
            bus.sum_valid <= 1'b0;
            bus.err       <= 1'b0;
            case (state)
                IDLE:
                    if (bus.op_valid) begin
                        bus.multiplier_input   <= bus.op_a;
                        bus.multiplicand_input <= bus.op_b;
                        last_q                 <= bus.op_last;
                        mask_q                 <= bus.add_mask;
                        bus.mStart             <= '1;
                        state                  <= START;
                        if (new_grp) begin
                            bus.beat_count <= '0;
                            new_grp        <= 1'b0;
                        end
                    end
                START:
                    state <= WAIT;
                WAIT:
                    if (all_ready) begin
                        bus.Add        <= mask_q;
                        bus.beat_count <= &bus.beat_count ? bus.beat_count : bus.beat_count + 1'b1;
                        state          <= ACCUM;
                    end else if (timeout) begin
                        bus.err <= 1'b1;
                        state   <= IDLE;
                    end
                ACCUM: begin
                    bus.sum_valid <= last_q;
                    state         <= last_q ? DONE : IDLE;
                end
                DONE: begin
                    new_grp <= 1'b1;
                    state   <= IDLE;
                end
                default:
                    state <= IDLE;
            endcase
        end

endmodule
